// File: rtl/dpram_stream_fifo_if.sv
// rtl/dpram_stream_fifo_if.sv - valid/ready word stream interface used on both FIFO sides
//
// Purpose: bundles one valid/ready word stream.
// Signals:
//   data   DATA_WIDTH  word carried by the stream
//   valid  1           source has a word on data
//   ready  1           sink accepts the word this cycle
// Modports:
//   master  drives data/valid, samples ready (stream source)
//   slave   samples data/valid, drives ready (stream sink)

interface dpram_stream_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/dpram_stream_fifo.sv
// rtl/dpram_stream_fifo.sv - streaming FIFO controller over an external dual-port SRAM
//
// Purpose: accepts words on the s stream, writes them into an external
// dual-port RAM, reads them back in order and presents them on the m stream
// through a one-entry output register. The RAM registers both of its ports on
// the falling edge of clk; this block works on the rising edge.
// Ports:
//   clk        in   1             clock shared with both RAM ports
//   rst_n      in   1             asynchronous reset, active-low
//   s          slave stream       write side (data/valid in, ready out)
//   m          master stream      read side (data/valid out, ready in)
//   mem_wen    out  1             RAM write enable
//   mem_waddr  out  ADDR_WIDTH    RAM write address
//   mem_wdata  out  DATA_WIDTH    RAM write data
//   mem_ren    out  1             RAM read enable
//   mem_raddr  out  ADDR_WIDTH    RAM read address
//   mem_rdata  in   DATA_WIDTH    RAM read data, valid after the falling edge of a ren cycle
//   level      out  ADDR_WIDTH+1  words held (RAM + output register)

module dpram_stream_fifo #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dpram_stream_fifo_if.slave    s,
  dpram_stream_fifo_if.master   m,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH:0]   level
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   used;        // words currently held in the RAM
  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;

  logic s_ready_c;
  logic push;
  logic rd;

  // Both decisions look only at registered occupancy, so a word written in a
  // cycle is never read in that same cycle: no same-address read/write can
  // reach the RAM, and a pop while full frees space only from the next cycle.
  always_comb begin
    s_ready_c = 1'b0;
    push      = 1'b0;
    rd        = 1'b0;
    s_ready_c = rst_n & (used != DEPTH);
    push      = s.valid & s_ready_c;
    rd        = rst_n & (used != '0) & (~m_valid_q | m.ready);
  end

  assign s.ready   = s_ready_c;

  assign mem_wen   = push;
  assign mem_waddr = wptr;
  assign mem_wdata = s.data;

  assign mem_ren   = rd;
  assign mem_raddr = rptr;

  assign m.valid   = m_valid_q;
  assign m.data    = m_data_q;

  assign level     = used + {{ADDR_WIDTH{1'b0}}, m_valid_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      used      <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (rd) begin
        rptr <= rptr + 1'b1;
      end
      used <= used + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, rd};

      // The RAM presented the read word at the falling edge of the rd cycle,
      // so it is already stable here and goes straight into the output register.
      if (rd) begin
        m_data_q  <= mem_rdata;
        m_valid_q <= 1'b1;
      end else if (m_valid_q && m.ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dpram_stream_fifo.sv
// tb/tb_dpram_stream_fifo.sv - self-checking bench for dpram_stream_fifo

module tb_dpram_stream_fifo;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_wen, mem_ren;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [AW:0]   level;

  always #5 clk = ~clk;

  dpram_stream_fifo_if #(.DATA_WIDTH(DW)) s_if ();
  dpram_stream_fifo_if #(.DATA_WIDTH(DW)) m_if ();

  dpram_stream_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (s_if),
    .m         (m_if),
    .mem_wen   (mem_wen),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .level     (level)
  );

  // Dual-port SRAM: both ports registered on the falling edge
  logic [DW-1:0] ram [DEPTH];
  always @(negedge clk) begin
    if (mem_wen) ram[mem_waddr] <= mem_wdata;
    if (mem_ren) mem_rdata <= ram[mem_raddr];
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model: words in RAM as a queue, plus the output slot
  logic [DW-1:0] ram_q[$];
  bit            out_v;
  logic [DW-1:0] out_d;
  int            wcnt, rcnt;
  bit            hold_prev;
  logic [DW-1:0] hold_data;

  // Observations of the most recent cycle
  bit            o_sready, o_mvalid, o_wen, o_ren;
  logic [DW-1:0] o_mdata;
  logic [AW-1:0] o_waddr, o_raddr;
  int            o_level;

  function automatic void chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endfunction

  function automatic void model_reset();
    ram_q.delete();
    out_v = 0;
    out_d = '0;
    wcnt = 0;
    rcnt = 0;
    hold_prev = 0;
  endfunction

  // Called at posedge+1; drives inputs, samples at posedge+4, returns at next posedge+1
  task automatic cycle(input bit sv, input logic [DW-1:0] sd, input bit mr);
    bit exp_acc, exp_fetch;
    s_if.valid = sv;
    s_if.data  = sd;
    m_if.ready = mr;
    #3;
    if (!rst_n) model_reset();
    exp_acc   = rst_n && sv && (ram_q.size() < DEPTH);
    exp_fetch = rst_n && (ram_q.size() != 0) && (!out_v || mr);
    o_sready = s_if.ready;
    o_mvalid = m_if.valid;
    o_mdata  = m_if.data;
    o_level  = int'(level);
    o_wen    = mem_wen;
    o_ren    = mem_ren;
    o_waddr  = mem_waddr;
    o_raddr  = mem_raddr;
    chk("s_ready", o_sready, rst_n && (ram_q.size() < DEPTH));
    chk("m_valid", o_mvalid, out_v);
    chk("m_data", o_mdata, out_d);
    chk("level", level, ram_q.size() + int'(out_v));
    chk("mem_wen", o_wen, exp_acc);
    chk("mem_ren", o_ren, exp_fetch);
    if (exp_acc) begin
      chk("mem_waddr", o_waddr, wcnt % DEPTH);
      chk("mem_wdata", mem_wdata, sd);
    end
    if (exp_fetch) chk("mem_raddr", o_raddr, rcnt % DEPTH);
    if (o_wen && o_ren) chk("rw_same_addr", o_waddr == o_raddr, 1'b0);
    if (hold_prev) begin
      chk("hold_valid", o_mvalid, 1'b1);
      chk("hold_data", o_mdata, hold_data);
    end
    hold_prev = rst_n && o_mvalid && !mr;
    hold_data = o_mdata;
    if (out_v && mr) out_v = 0;
    if (exp_fetch) begin
      out_d = ram_q.pop_front();
      out_v = 1;
      rcnt++;
    end
    if (exp_acc) begin
      ram_q.push_back(sd);
      wcnt++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w, acc, rx, pushed, received;
    logic [DW-1:0] cur;
    bit sv, mr;

    model_reset();
    s_if.valid = 1'b1;
    s_if.data  = 32'h5555_5555;
    m_if.ready = 1'b1;
    @(posedge clk);
    #1;

    // 1: reset held with s_valid asserted
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h5555_5555, 1'b1);
      chk("rst_s_ready", o_sready, 1'b0);
      chk("rst_mem_wen", o_wen, 1'b0);
      chk("rst_mem_ren", o_ren, 1'b0);
      chk("rst_level", o_level, 0);
    end
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b1);
    chk("release_s_ready", o_sready, 1'b1);

    // 2: single word latency
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1);
    chk("t2_wen", o_wen, 1'b1);
    chk("t2_waddr", o_waddr, 0);
    chk("t2_level0", o_level, 0);
    cycle(1'b0, '0, 1'b1);
    chk("t2_ren", o_ren, 1'b1);
    chk("t2_raddr", o_raddr, 0);
    chk("t2_level1", o_level, 1);
    cycle(1'b0, '0, 1'b1);
    chk("t2_mvalid", o_mvalid, 1'b1);
    chk("t2_mdata", o_mdata, 32'hDEAD_BEEF);
    chk("t2_level2", o_level, 1);
    cycle(1'b0, '0, 1'b1);
    chk("t2_level3", o_level, 0);

    // 3: fill with m_ready low
    w = 0;
    acc = 0;
    for (int c = 0; c < 1400 && w <= 1100; c++) begin
      cycle(1'b1, w, 1'b0);
      if (o_sready) begin
        w++;
        acc++;
      end
    end
    chk("fill_accepted", acc, 1025);
    cycle(1'b1, w, 1'b0);
    chk("full_s_ready", o_sready, 1'b0);
    chk("full_level", o_level, 1025);
    chk("full_m_data", o_mdata, 0);
    cycle(1'b1, w, 1'b1);
    chk("pop_full_s_ready", o_sready, 1'b0);
    cycle(1'b1, w, 1'b1);
    chk("after_pop_s_ready", o_sready, 1'b1);
    for (int c = 0; c < 1200 && (ram_q.size() + int'(out_v)) != 0; c++)
      cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("drained_level", o_level, 0);

    // 4: sustained streaming with wrap
    w = 0;
    rx = 0;
    for (int c = 0; c < 3002; c++) begin
      cycle(w < 3000, w, 1'b1);
      if (w < 3000 && o_sready) w++;
      if (o_mvalid) begin
        chk("stream_order", o_mdata, rx);
        rx++;
      end
    end
    chk("stream_pushed", w, 3000);
    chk("stream_received", rx, 3000);

    // 5: random traffic
    pushed = 0;
    received = 0;
    cur = $urandom;
    for (int c = 0; c < 40000 && received < 5000; c++) begin
      sv = (pushed < 5000) && ($urandom_range(0, 3) != 0);
      if (((c / 1500) % 2) == 1) mr = ($urandom_range(0, 3) == 0);
      else                       mr = ($urandom_range(0, 2) != 0);
      cycle(sv, cur, mr);
      if (sv && o_sready) begin
        pushed++;
        cur = $urandom;
      end
      if (o_mvalid && mr) received++;
    end
    chk("random_received", received, 5000);

    // 6: reset mid-stream discards queued data
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'hA000_0000 + i, 1'b0);
    chk("t6_queued", o_level, 9);
    cycle(1'b0, '0, 1'b0);
    chk("t6_queued10", o_level, 10);
    rst_n = 1'b0;
    cycle(1'b0, '0, 1'b1);
    chk("t6_rst_level", o_level, 0);
    chk("t6_rst_mvalid", o_mvalid, 1'b0);
    rst_n = 1'b1;
    cycle(1'b1, 32'h1, 1'b1);
    chk("t6_push", o_wen, 1'b1);
    chk("t6_level0", o_level, 0);
    cycle(1'b0, '0, 1'b1);
    chk("t6_gap_mvalid", o_mvalid, 1'b0);
    cycle(1'b0, '0, 1'b1);
    chk("t6_first_valid", o_mvalid, 1'b1);
    chk("t6_first_data", o_mdata, 32'h1);
    cycle(1'b0, '0, 1'b1);
    chk("t6_empty", o_level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
